// File: rtl/cpu_stage_ctrl.sv
// ============================================================================
// Module  : cpu_stage_ctrl
// Purpose : Stage sequencer for the multicycle CPU core. Rotates through
//           NUM_STAGES stages and emits one-hot latch enables for the
//           per-stage bundle registers. Also inserts fetch wait states,
//           stalls write-back on memory busy, inserts an interrupt-entry
//           cycle with acknowledge, and counts retired instructions.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_stage_ctrl #(
  parameter int NUM_STAGES = 3,   // 2..8; stage 0 = fetch, last = execute/write
  parameter int MEM_WAIT   = 0,   // 0..15 extra fetch cycles
  parameter int CNT_W      = 32,  // retired-instruction counter width
  localparam int SW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_busy,
  input  logic                  irr,
  input  logic                  irq_en,
  output logic [SW-1:0]         stage,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  stall,
  output logic                  retire,
  output logic                  ack,
  output logic [CNT_W-1:0]      retire_count
);

  // Stage index of the final (execute/write) stage and the fetch wait reload.
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] FETCH      = '0;
  localparam logic [3:0]    WAIT_INIT  = 4'(MEM_WAIT);

  // RUN walks the stages; IRQ is the single cycle inserted after a retire
  // that saw an enabled interrupt request.
  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_IRQ = 1'b1
  } mode_t;

  logic [SW-1:0]         stage_q, stage_d;
  logic [3:0]            wait_q,  wait_d;
  mode_t                 mode_q,  mode_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  logic [NUM_STAGES-1:0] onehot;
  logic [NUM_STAGES-1:0] en_raw;
  logic                  stall_raw;
  logic                  retire_raw;
  logic                  ack_raw;

  // One-hot decode of the current stage index.
  assign onehot = NUM_STAGES'(1) << stage_q;

  // Next-state and output decode; outputs depend only on state and inputs.
  always_comb begin
    stage_d    = stage_q;
    wait_d     = wait_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    en_raw     = '0;
    stall_raw  = 1'b0;
    retire_raw = 1'b0;
    ack_raw    = 1'b0;

    if (mode_q == MODE_IRQ) begin
      // Interrupt-entry cycle: acknowledge, then restart fetch with a
      // fresh wait count.
      ack_raw = 1'b1;
      stage_d = FETCH;
      wait_d  = WAIT_INIT;
      mode_d  = MODE_RUN;
    end else if (stage_q == LAST_STAGE) begin
      if (w_busy) begin
        // Write port busy: hold the final stage; interrupt sampling is
        // deferred to the cycle in which busy drops.
        stall_raw = 1'b1;
      end else begin
        en_raw     = onehot;
        retire_raw = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        stage_d    = FETCH;
        wait_d     = WAIT_INIT;
        if (irr && irq_en) begin
          mode_d = MODE_IRQ;
        end
      end
    end else if (stage_q == FETCH) begin
      if (wait_q != 4'd0) begin
        // Instruction memory still busy: burn a wait state.
        wait_d = wait_q - 4'd1;
      end else begin
        en_raw  = onehot;
        stage_d = SW'(1);
      end
    end else begin
      // Intermediate stages take exactly one cycle each.
      en_raw  = onehot;
      stage_d = stage_q + SW'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= FETCH;
      wait_q  <= WAIT_INIT;
      mode_q  <= MODE_RUN;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are suppressed while reset is asserted so no bundle register
  // latches and no acknowledge escapes during reset. stage_q is already 0
  // during the IRQ cycle because retire loads fetch before entering IRQ.
  assign stage        = reset ? FETCH : stage_q;
  assign stage_en     = reset ? '0    : en_raw;
  assign stall        = reset ? 1'b0  : stall_raw;
  assign retire       = reset ? 1'b0  : retire_raw;
  assign ack          = reset ? 1'b0  : ack_raw;
  assign retire_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_stage_ctrl.sv
// ============================================================================
// Module  : tb_cpu_stage_ctrl
// Purpose : Directed self-checking bench for cpu_stage_ctrl. Three instances:
//           A = defaults, B = NUM_STAGES 5 / MEM_WAIT 2, C = CNT_W 4.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;

  // Instance A: defaults
  logic        rst_a, busy_a, irr_a, irqen_a;
  logic [1:0]  stage_a;
  logic [2:0]  en_a;
  logic        stall_a, ret_a, ack_a;
  logic [31:0] cnt_a;

  // Instance B: 5 stages, 2 fetch wait states
  logic        rst_b, busy_b, irr_b, irqen_b;
  logic [2:0]  stage_b;
  logic [4:0]  en_b;
  logic        stall_b, ret_b, ack_b;
  logic [31:0] cnt_b;

  // Instance C: 4-bit counter
  logic        rst_c, busy_c, irr_c, irqen_c;
  logic [1:0]  stage_c;
  logic [2:0]  en_c;
  logic        stall_c, ret_c, ack_c;
  logic [3:0]  cnt_c;

  cpu_stage_ctrl u_a (
    .clk(clk), .reset(rst_a), .w_busy(busy_a), .irr(irr_a), .irq_en(irqen_a),
    .stage(stage_a), .stage_en(en_a), .stall(stall_a), .retire(ret_a),
    .ack(ack_a), .retire_count(cnt_a)
  );

  cpu_stage_ctrl #(.NUM_STAGES(5), .MEM_WAIT(2)) u_b (
    .clk(clk), .reset(rst_b), .w_busy(busy_b), .irr(irr_b), .irq_en(irqen_b),
    .stage(stage_b), .stage_en(en_b), .stall(stall_b), .retire(ret_b),
    .ack(ack_b), .retire_count(cnt_b)
  );

  cpu_stage_ctrl #(.CNT_W(4)) u_c (
    .clk(clk), .reset(rst_c), .w_busy(busy_c), .irr(irr_c), .irq_en(irqen_c),
    .stage(stage_c), .stage_en(en_c), .stall(stall_c), .retire(ret_c),
    .ack(ack_c), .retire_count(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; busy_a = 1'b0; irr_a = 1'b0; irqen_a = 1'b0;
    rst_b = 1'b1; busy_b = 1'b0; irr_b = 1'b0; irqen_b = 1'b0;
    rst_c = 1'b1; busy_c = 1'b0; irr_c = 1'b0; irqen_c = 1'b0;

    // ---- reset state (A) ----
    tick(); tick();
    busy_a = 1'b1; irr_a = 1'b1; irqen_a = 1'b1;
    #1;
    check("rst_stage",  32'(stage_a), 0);
    check("rst_en",     32'(en_a),    0);
    check("rst_stall",  32'(stall_a), 0);
    check("rst_retire", 32'(ret_a),   0);
    check("rst_ack",    32'(ack_a),   0);
    check("rst_count",  cnt_a,        0);
    busy_a = 1'b0; irr_a = 1'b0; irqen_a = 1'b0;

    // ---- plain rotation (A) ----
    rst_a = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rot_stage",  32'(stage_a), 32'(i % 3));
      check("rot_en",     32'(en_a),    32'(1 << (i % 3)));
      check("rot_retire", 32'(ret_a),   32'((i % 3) == 2));
      tick(); #1;
    end
    check("rot_count", cnt_a, 2);

    // ---- write-busy stall with irr held, irr dropped as busy drops (A) ----
    tick(); #1;                                   // stage 1
    tick();                                       // stage 2
    busy_a = 1'b1; irr_a = 1'b1; irqen_a = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      check("stl_stall", 32'(stall_a), 1);
      check("stl_en",    32'(en_a),    0);
      check("stl_stage", 32'(stage_a), 2);
      check("stl_ret",   32'(ret_a),   0);
      check("stl_ack",   32'(ack_a),   0);
      tick(); #1;
    end
    busy_a = 1'b0; irr_a = 1'b0;
    #1;
    check("stl_rel_ret",   32'(ret_a),   1);
    check("stl_rel_en",    32'(en_a),    4);
    check("stl_rel_stall", 32'(stall_a), 0);
    tick(); #1;
    check("stl_after_stage", 32'(stage_a), 0);
    check("stl_after_ack",   32'(ack_a),   0);
    check("stl_after_en",    32'(en_a),    1);
    check("stl_after_cnt",   cnt_a,        3);

    // ---- interrupt taken at retire (A) ----
    tick(); #1;                                   // stage 1
    tick();                                       // stage 2
    irr_a = 1'b1; irqen_a = 1'b1;
    #1;
    check("irq_ret", 32'(ret_a), 1);
    tick();
    irr_a = 1'b0;
    #1;
    check("irq_ack",   32'(ack_a),   1);
    check("irq_stage", 32'(stage_a), 0);
    check("irq_en",    32'(en_a),    0);
    tick(); #1;
    check("irq_next_ack", 32'(ack_a), 0);
    check("irq_next_en",  32'(en_a),  1);

    // ---- interrupt masked (A) ----
    tick(); #1;                                   // stage 1
    tick();                                       // stage 2
    irr_a = 1'b1; irqen_a = 1'b0;
    #1;
    check("msk_ret", 32'(ret_a), 1);
    tick(); #1;
    check("msk_ack", 32'(ack_a), 0);
    check("msk_en",  32'(en_a),  1);

    // ---- irr high only at stage 1 (A) ----
    tick();                                       // stage 1
    irr_a = 1'b1; irqen_a = 1'b1;
    #1;
    check("early_en", 32'(en_a), 2);
    tick();                                       // stage 2
    irr_a = 1'b0;
    #1;
    check("early_ret", 32'(ret_a), 1);
    tick(); #1;
    check("early_ack", 32'(ack_a), 0);
    check("early_nx",  32'(en_a),  1);
    check("early_cnt", cnt_a,      6);

    // ---- reset during a stalled final stage with irr pending (A) ----
    tick(); #1;                                   // stage 1
    tick();                                       // stage 2
    busy_a = 1'b1; irr_a = 1'b1; irqen_a = 1'b1;
    #1;
    check("mrst_pre_stall", 32'(stall_a), 1);
    rst_a = 1'b1;
    #1;
    check("mrst_stall", 32'(stall_a), 0);
    check("mrst_en",    32'(en_a),    0);
    check("mrst_ack",   32'(ack_a),   0);
    tick(); #1;
    check("mrst_stage", 32'(stage_a), 0);
    check("mrst_cnt",   cnt_a,        0);
    check("mrst_ack2",  32'(ack_a),   0);
    rst_a = 1'b0; busy_a = 1'b0;
    #1;
    check("mrst_c0_ack", 32'(ack_a), 0);
    check("mrst_c0_en",  32'(en_a),  1);
    tick();
    irr_a = 1'b0;
    #1;
    check("mrst_c1_ack", 32'(ack_a), 0);
    tick(); #1;
    check("mrst_c2_ret", 32'(ret_a), 1);
    tick(); #1;
    check("mrst_c3_ack",   32'(ack_a),   0);
    check("mrst_c3_stage", 32'(stage_a), 0);

    // ---- 5 stages, 2 wait states (B) ----
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 14; i++) begin
      int ph;
      ph = i % 7;
      check("b_en",     32'(en_b),    (ph < 2) ? 32'd0 : 32'(1 << (ph - 2)));
      check("b_stage",  32'(stage_b), (ph < 2) ? 32'd0 : 32'(ph - 2));
      check("b_retire", 32'(ret_b),   32'(ph == 6));
      tick(); #1;
    end
    check("b_count", cnt_b, 2);

    // ---- 4-bit counter wrap (C) ----
    rst_c = 1'b0;
    #1;
    for (int i = 0; i <= 51; i++) begin
      if (i == 45) check("c_cnt15", 32'(cnt_c), 15);
      if (i == 48) check("c_cnt_wrap", 32'(cnt_c), 0);
      if (i == 51) check("c_cnt1", 32'(cnt_c), 1);
      if (i < 51) begin
        tick(); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

`default_nettype wire
